// File: rtl/shazam_pkg.sv
// Shared types for the fingerprint path: band geometry, the packed {bin, magnitude}
// peak entry, and a helper that zeroes entries that fall below a magnitude floor.
// Latency: n/a (types only). Backpressure: n/a.
package shazam_pkg;

  localparam int NUM_BINS  = 512;
  localparam int NUM_BANDS = 16;
  localparam int BAND_SIZE = NUM_BINS / NUM_BANDS;
  localparam int MAG_W     = 16;
  localparam int IDX_W     = $clog2(NUM_BINS);
  localparam int OFF_W     = $clog2(BAND_SIZE);
  localparam int BAND_W    = $clog2(NUM_BANDS);

  typedef struct packed {
    logic [IDX_W-1:0] bin;
    logic [MAG_W-1:0] mag;
  } peak_t;

  typedef peak_t peaks_t [NUM_BANDS];

  // Entries quieter than the floor are reported as all-zero so the transmitter
  // can tell "no meaningful peak" apart from a real one.
  function automatic peak_t floor_peak(input peak_t p, input logic [MAG_W-1:0] min_mag);
    return (p.mag < min_mag) ? peak_t'('0) : p;
  endfunction

endpackage

// File: rtl/band_max_tracker.sv
// Running {bin, magnitude} maximum for the band currently streaming past.
// Latency: winner is combinational over the current sample; state updates 1 clk later.
// Backpressure: none; accepts a sample every cycle.
// Ports: clear (drop running max), sample (candidate present), load (first candidate
// of a band, taken unconditionally), cand (current {bin, mag}), winner (max incl. cand).
module band_max_tracker
  import shazam_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  sample,
  input  logic  load,
  input  peak_t cand,
  output peak_t winner
);

  peak_t run_max;

  // Strict compare: on a tie the earlier (lower) bin is kept.
  always_comb begin
    winner = run_max;
    if (load || (cand.mag > run_max.mag)) begin
      winner = cand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_max <= '0;
    end else if (clear) begin
      run_max <= '0;
    end else if (sample) begin
      run_max <= winner;
    end
  end

endmodule

// File: rtl/band_peak_finder.sv
// Per-band loudest-bin finder over a 512-bin magnitude frame; publishes 16 {bin, mag} maxima.
// Latency: maximas/maximas_found update 1 clk after the bin-511 strobe.
// Backpressure: none; strobes may arrive every cycle, frame_sync aborts the partial frame.
// Ports: clk, reset (async, active-high), magnitude_ready/magnitude (bin stream),
// frame_sync (realign to bin 0), maximas (entry b = {bin, mag}), maximas_found, bin_count.
module band_peak_finder
  import shazam_pkg::*;
#(
  parameter logic [MAG_W-1:0] MIN_MAG = '0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        magnitude_ready,
  input  logic [MAG_W-1:0]                            magnitude,
  input  logic                                        frame_sync,
  output logic [NUM_BANDS-1:0][IDX_W+MAG_W-1:0]       maximas,
  output logic                                        maximas_found,
  output logic [IDX_W-1:0]                            bin_count
);

  logic [BAND_W-1:0] band;
  logic [OFF_W-1:0]  offset;
  logic              cand_vld;
  logic              first_cand;
  logic              band_end;
  logic              frame_end;
  peak_t             cand;
  peak_t             winner;
  peak_t             committed;
  peak_t             staging [NUM_BANDS];

  assign band   = bin_count[IDX_W-1:OFF_W];
  assign offset = bin_count[OFF_W-1:0];

  // DC (bin 0) is counted but never competes; a sync cycle's sample is also bin 0.
  assign cand_vld   = magnitude_ready && !frame_sync && (bin_count != '0);
  assign first_cand = (offset == '0) || (bin_count == IDX_W'(1));
  assign band_end   = cand_vld && (offset == '1);
  assign frame_end  = band_end && (band == '1);

  assign cand.bin = bin_count;
  assign cand.mag = magnitude;

  assign committed = floor_peak(winner, MIN_MAG);

  band_max_tracker u_tracker (
    .clk    (clk),
    .rst    (reset),
    .clear  (frame_sync),
    .sample (cand_vld),
    .load   (first_cand),
    .cand   (cand),
    .winner (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_count     <= '0;
      maximas       <= '0;
      maximas_found <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        staging[b] <= '0;
      end
    end else begin
      maximas_found <= 1'b0;

      if (frame_sync) begin
        bin_count <= magnitude_ready ? IDX_W'(1) : '0;
      end else if (magnitude_ready) begin
        bin_count <= bin_count + IDX_W'(1);
      end

      if (band_end) begin
        staging[band] <= committed;
      end

      // Last band bypasses staging so the whole set lands on the same edge.
      if (frame_end) begin
        for (int b = 0; b < NUM_BANDS-1; b++) begin
          maximas[b] <= staging[b];
        end
        maximas[NUM_BANDS-1] <= committed;
        maximas_found        <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_band_peak_finder.sv
// Scoreboard bench for band_peak_finder: two instances (no floor, floor of 20) share
// the same stimulus; expected frames are queued at the bin-511 strobe and popped by
// a monitor on each maximas_found pulse, which also checks the 1-clk latency.
module tb_band_peak_finder;
  import shazam_pkg::*;

  typedef logic [NUM_BANDS-1:0][IDX_W+MAG_W-1:0] frame_t;
  typedef logic [IDX_W+MAG_W-1:0] ent_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             magnitude_ready = 1'b0;
  logic             frame_sync = 1'b0;
  logic [MAG_W-1:0] magnitude = '0;
  frame_t           max0, max1;
  logic             found0, found1;
  logic [IDX_W-1:0] bc0, bc1;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     fm [NUM_BINS];
  frame_t q0 [$];
  frame_t q1 [$];
  int     qd0 [$];
  int     qd1 [$];
  frame_t last0 = '0;

  band_peak_finder #(.MIN_MAG(16'd0)) dut0 (
    .clk(clk), .reset(reset), .magnitude_ready(magnitude_ready), .magnitude(magnitude),
    .frame_sync(frame_sync), .maximas(max0), .maximas_found(found0), .bin_count(bc0)
  );

  band_peak_finder #(.MIN_MAG(16'd20)) dut1 (
    .clk(clk), .reset(reset), .magnitude_ready(magnitude_ready), .magnitude(magnitude),
    .frame_sync(frame_sync), .maximas(max1), .maximas_found(found1), .bin_count(bc1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ent_t ent(input int bin, input int mag);
    peak_t p;
    p.bin = IDX_W'(bin);
    p.mag = MAG_W'(mag);
    return p;
  endfunction

  // Frame-level reference: scan each band's candidates, keep first occurrence of the max.
  function automatic frame_t ref_frame(input int minm);
    frame_t f;
    for (int b = 0; b < NUM_BANDS; b++) begin
      int lo = (b == 0) ? 1 : b * BAND_SIZE;
      int bb = lo;
      int best = fm[lo];
      for (int i = lo + 1; i < (b + 1) * BAND_SIZE; i++) begin
        if (fm[i] > best) begin
          best = fm[i];
          bb = i;
        end
      end
      f[b] = (best < minm) ? ent_t'(0) : ent(bb, best);
    end
    return f;
  endfunction

  task automatic chk_frame(input string name, input frame_t act, input frame_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ent(input string name, input ent_t act, input ent_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got bin %0d mag %0d expected bin %0d mag %0d",
               name, act[24:16], act[15:0], exp[24:16], exp[15:0]);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int m, input logic s);
    magnitude       = MAG_W'(m);
    magnitude_ready = 1'b1;
    frame_sync      = s;
    @(posedge clk);
    #1;
    magnitude_ready = 1'b0;
    frame_sync      = 1'b0;
  endtask

  task automatic play(input int lo, input int hi, input int maxgap);
    for (int i = lo; i <= hi; i++) begin
      send(fm[i], 1'b0);
      if (i == NUM_BINS - 1) begin
        last0 = ref_frame(0);
        q0.push_back(last0);
        q1.push_back(ref_frame(20));
        qd0.push_back(cyc);
        qd1.push_back(cyc);
      end
      if (maxgap > 0) begin
        repeat ($urandom_range(0, maxgap)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic fill(input int bg, input int spike_bin, input int spike_mag);
    for (int i = 0; i < NUM_BINS; i++) fm[i] = bg;
    if (spike_bin >= 0) fm[spike_bin] = spike_mag;
  endtask

  // Monitor: every pulse must match the oldest queued frame and arrive on its due cycle.
  always @(negedge clk) begin
    frame_t e;
    int     d;
    if (!reset) begin
      if (found0) begin
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL found0: unexpected pulse at cycle %0d", cyc);
        end else begin
          e = q0.pop_front();
          d = qd0.pop_front();
          if (max0 !== e || cyc != d) begin
            errors++;
            $display("FAIL frame0: cycle %0d due %0d got %h expected %h", cyc, d, max0, e);
          end
        end
      end
      if (found1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL found1: unexpected pulse at cycle %0d", cyc);
        end else begin
          e = q1.pop_front();
          d = qd1.pop_front();
          if (max1 !== e || cyc != d) begin
            errors++;
            $display("FAIL frame1: cycle %0d due %0d got %h expected %h", cyc, d, max1, e);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    #1;
    chk_int("reset_bin_count", int'(bc0), 0);
    chk_frame("reset_maximas", max0, '0);
    chk_int("reset_found", int'(found0), 0);
    #22 reset = 1'b0;
    @(posedge clk);
    #1;

    // Constant 100 with idle gaps: lowest candidate bin of each band wins ties
    fill(100, -1, 0);
    play(0, NUM_BINS - 1, 1);
    @(negedge clk);
    chk_ent("const_e0", max0[0], ent(1, 100));
    chk_ent("const_e7", max0[7], ent(224, 100));
    chk_ent("const_e15_floor", max1[15], ent(480, 100));

    // Ramp with a loud DC bin that must be ignored
    for (int i = 0; i < NUM_BINS; i++) fm[i] = i;
    fm[0] = 65535;
    play(0, NUM_BINS - 1, 0);
    @(negedge clk);
    chk_ent("ramp_e0", max0[0], ent(31, 31));
    chk_ent("ramp_e15", max0[15], ent(511, 511));

    // Single spike; floored instance zeroes the quiet bands
    fill(10, 300, 5000);
    play(0, NUM_BINS - 1, 0);
    @(negedge clk);
    chk_ent("spike_e9", max0[9], ent(300, 5000));
    chk_ent("spike_e4", max0[4], ent(128, 10));
    chk_ent("spike_floor_e4", max1[4], ent(0, 0));
    chk_ent("spike_floor_e9", max1[9], ent(300, 5000));

    // Three back-to-back frames with distinct spikes
    fill(10, 40, 3000);
    play(0, NUM_BINS - 1, 0);
    fill(10, 200, 4000);
    play(0, NUM_BINS - 1, 0);
    fill(10, 450, 6000);
    play(0, NUM_BINS - 1, 0);

    // Abort at bin 250 of a frame spiking at 100, then a clean frame
    fill(10, 100, 9000);
    play(0, 249, 0);
    chk_frame("abort_hold", max0, last0);
    fill(7, -1, 0);
    send(fm[0], 1'b1);
    chk_int("sync_with_strobe_bin_count", int'(bc0), 1);
    play(1, NUM_BINS - 1, 0);
    @(negedge clk);
    chk_ent("clean_e3", max0[3], ent(96, 7));

    // Sync coinciding with the bin-511 strobe suppresses the commit
    fill(3, 60, 900);
    play(0, NUM_BINS - 2, 0);
    send(fm[NUM_BINS - 1], 1'b1);
    chk_int("sync_at_511_bin_count", int'(bc1), 1);
    play(1, NUM_BINS - 1, 0);

    // Asynchronous reset mid-frame, between edges
    for (int i = 0; i < NUM_BINS; i++) fm[i] = (i * 37) % 1000;
    play(0, 179, 0);
    #2 reset = 1'b1;
    #1;
    chk_frame("async_reset_maximas0", max0, '0);
    chk_frame("async_reset_maximas1", max1, '0);
    chk_int("async_reset_bin_count", int'(bc0), 0);
    chk_int("async_reset_found", int'(found0), 0);
    @(posedge clk);
    #3 reset = 1'b0;
    play(0, NUM_BINS - 1, 0);

    repeat (3) @(negedge clk);
    chk_int("pending_frames0", q0.size(), 0);
    chk_int("pending_frames1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/band_peak_finder.md
Name: band_peak_finder

Overview:
- Downstream of the magnitude stage in the analyze-sounds path; consumes the serial stream of 512 single-sided FFT magnitudes per frame.
- Splits bins 1..511 into 16 bands of 32 bins and tracks the loudest bin of each band.
- At frame end, publishes 16 packed {bin, magnitude} maxima plus a one-cycle found strobe for the SPI fingerprint transmitter.

Parameters:
- NUM_BINS, 512, magnitudes per frame; power of two.
- NUM_BANDS, 16, bands per frame; BAND_SIZE = NUM_BINS/NUM_BANDS = 32.
- MAG_W, 16, magnitude width.
- IDX_W, 9, bin index width = log2(NUM_BINS).
- MIN_MAG, 0, band maxima below this value are reported as all-zero entries; 0 disables the check.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- magnitude_ready  in  1  one-cycle strobe; magnitude holds the next bin.
- magnitude  in  MAG_W  unsigned magnitude, sampled when magnitude_ready=1.
- frame_sync  in  1  one-cycle strobe; realigns the bin counter to 0 and discards the partial frame.
- maximas  out  [NUM_BANDS-1:0][IDX_W+MAG_W-1:0]  entry b = {bin[8:0], mag[15:0]}, i.e. bits [24:16] bin and [15:0] magnitude.
- maximas_found  out  1  one-cycle pulse; maximas just updated.
- bin_count  out  IDX_W  current expected bin (debug/verification).

Behaviour:
- Reset (asynchronous, active-high):
  - bin_count=0; all maximas entries=0; maximas_found=0.
  - Running max cleared; staging bank cleared.
- Bin counter:
  - Increments on each magnitude_ready; wraps 511->0.
  - band = bin_count[8:5]; offset = bin_count[4:0].
- Bin 0 (DC):
  - Counted but never a candidate.
  - Band 0 candidates are bins 1..31.
- Running max, on a strobe at a candidate bin:
  - First candidate of the band (offset==0, or bin 1 for band 0): load {bin, magnitude} unconditionally.
  - Otherwise replace only if magnitude > running magnitude (strict), so the lowest bin wins ties.
- Band commit:
  - On the strobe with offset==31, the winner, including the current sample, is written to staging[band].
  - If winner magnitude < MIN_MAG, write 25'd0 instead.
- Frame commit:
  - On the strobe for bin 511, band 15 is committed as above.
  - Bands 0..14 from staging and band 15's winner are copied into maximas in the same edge.
  - maximas_found=1 for exactly the next cycle, so latency is 1 clk from the bin-511 strobe.
- Output hold: maximas is stable between commits; a partial frame never alters it.
- Back-to-back strobes (every cycle) must be supported; no stall, no ready output.
- frame_sync:
  - Next bin_count=0; running max invalidated; staging not copied.
  - frame_sync and magnitude_ready in the same cycle: that sample is taken as bin 0 of the new frame (DC, ignored), and next bin_count=1.
- frame_sync coinciding with the bin-511 strobe: the frame commit is suppressed; sync wins.
- Reset mid-frame: everything cleared; the first strobe after reset release is bin 0.
- Widths: unsigned compares only; no arithmetic growth; bin field always equals absolute bin 1..511, or 0 for a zeroed entry.
- No combinational path from inputs to outputs.

Decomposition:
- shazam_pkg holds:
  - localparams NUM_BINS, NUM_BANDS, BAND_SIZE, MAG_W, IDX_W;
  - typedef peak_t = struct packed {logic [IDX_W-1:0] bin; logic [MAG_W-1:0] mag;}, 25 bits;
  - typedef peak_t peaks_t [NUM_BANDS].
- One natural sub-module, band_max_tracker: holds the running max, with load/compare/commit inputs and a winner output.
- Counter, staging bank and frame commit stay in band_peak_finder.

Test Plan:
- Constant input, all 512 magnitudes = 100.
  - After the bin-511 strobe: maximas_found pulses once.
  - Entry 0 = {1,100}; entry b = {32b,100} for b=1..15 (lowest bin wins ties).
- Ramp, magnitude = bin.
  - Entry b = {32b+31, 32b+31}.
  - Bin 0 ignored even when the DC value is set to 65535.
- Single spike: 5000 at bin 300, all other bins 10.
  - Entry 9 = {300,5000}; other entries at their band's lowest candidate bin with mag 10.
  - Rerun with MIN_MAG=20: all entries except 9 are 25'd0.
- Back-to-back strobes for 3 frames with distinct spikes (bins 40, 200, 450).
  - Three pulses, each exactly 1 clk after the bin-511 strobe.
  - Each update reflects only its own frame's spike.
- frame_sync asserted at bin 250 of a frame with a spike at bin 100, then a full clean frame.
  - No pulse for the aborted frame; maximas unchanged until the clean frame.
  - The clean frame's results contain no trace of the bin-100 spike.
- Reset asserted asynchronously mid-frame (bin 180, between clk edges).
  - Outputs zero immediately; bin_count=0.
  - The next 512 strobes produce one correct frame commit.
